uart_frame_ctrl: RTL and testbench
==================================

// Module: uart_frame_ctrl
// PURPOSE
//  Frame-level controller downstream of the 115200-baud UART byte receiver (50 MHz iCLK).
//  Consumes byte strobes; parses frames SYNC,ADDR,LEN,DATA[LEN],CHK; buffers the payload.
//  Commits the payload as a burst of register writes only when the checksum matches.
//  Aborts on length error, checksum error, inter-byte timeout or overrun.
// PARAMETERS
//  SYNC_BYTE    8'hAA  frame start marker
//  MAX_LEN      16     max payload bytes; sets buffer depth
//  TIMEOUT_CYC  8680   inter-byte timeout in iCLK cycles (2 byte times at 115200)
// PORTS
//  iCLK       in   1  system clock, 50 MHz
//  RST_n      in   1  asynchronous, active-low reset
//  rx_byte    in   8  received byte; valid when rx_valid=1
//  rx_valid   in   1  one-cycle byte strobe from receiver (RECEIVE_END)
//  wr_en      out  1  register-write strobe
//  wr_addr    out  8  write address
//  wr_data    out  8  write data
//  frame_ok   out  1  one-cycle pulse: frame fully committed
//  frame_err  out  1  one-cycle pulse: frame aborted
//  err_code   out  2  0=LEN 1=CHK 2=TIMEOUT 3=OVERRUN; held until next frame_err
//  busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0, buffer contents don't-care.
//  Reset mid-frame discards the frame; no write is issued for it.
//  All outputs are registered.
//  States:
//   IDLE: rx_valid & byte==SYNC_BYTE -> ADDR. Other bytes ignored; no error raised.
//   ADDR: on rx_valid, latch base address and seed sum=byte -> LEN.
//   LEN: on rx_valid, if byte==0 or byte>MAX_LEN -> frame_err, code LEN, -> IDLE.
//     Otherwise latch len, sum+=byte, idx=0 -> DATA.
//   DATA: on rx_valid, buf[idx]=byte, sum+=byte, idx++. When idx reaches len-1 -> CHK.
//   CHK: on rx_valid, if byte==sum[7:0] -> COMMIT.
//     Otherwise frame_err, code CHK, -> IDLE.
//   COMMIT: one write per cycle; wr_addr=base+i (mod 256); wr_data=buf[i]; i=0..len-1.
//     frame_ok is asserted in the same cycle as the last wr_en, then -> IDLE.
//  Latency: CHK byte accepted in cycle t -> wr_en high in cycles t+1..t+len.
//   frame_ok in cycle t+len.
//  Checksum: 8-bit modulo-256 sum of ADDR, LEN and all DATA bytes. SYNC is excluded.
//  Timeout:
//   - Counter clears on every rx_valid and runs only in ADDR, LEN, DATA and CHK.
//   - On reaching TIMEOUT_CYC: frame_err, code TIMEOUT, -> IDLE.
//   - If rx_valid arrives in the same cycle the counter reaches TIMEOUT_CYC, the byte wins and no timeout is raised.
//  Overrun: rx_valid during COMMIT drops the byte.
//   - The commit still completes.
//   - frame_err (code OVERRUN) pulses in the cycle after frame_ok.
//  Address wrap: base 0xFF with len 2 writes 0xFF then 0x00.
//  A SYNC_BYTE value inside ADDR, LEN, DATA or CHK is treated as ordinary data.
// STRUCTURE
//  uart_frame_defs.vh: state encodings, ERR_* codes, SYNC_BYTE default.
//  Sub-module frame_buf: MAX_LEN x 8 register file.
//   - 1 write port, 1 read port, combinational read.
//   - Address width $clog2(MAX_LEN).
//  Top level: FSM, sum accumulator, idx/len counters, timeout counter.
//   - Timeout counter width is $clog2(TIMEOUT_CYC+1).
// TESTING
//  1. AA 10 02 11 22 45 -> wr (0x10,0x11),(0x11,0x22) on consecutive cycles; frame_ok with 2nd wr.
//  2. AA 10 02 11 22 46 -> no wr_en; frame_err, err_code=1; busy falls next cycle.
//  3. AA 10 00, then AA 10 11 -> frame_err code 0 each time; FSM back in IDLE.
//  4. AA 10 02 11, then silence 8680 cycles -> frame_err code 2.
//     Repeat with a byte at exactly cycle 8680 -> no error.
//  5. AA FF 02 01 02 04 -> wr (0xFF,0x01),(0x00,0x02).
//     Repeat with a strobe during COMMIT -> frame_ok, then frame_err code 3.
//  6. Assert RST_n low during DATA of a valid frame -> no writes.
//     Next full valid frame commits correctly.

Source files
------------

// File: rtl/uart_frame_ctrl_pkg.sv
// Shared types for the UART frame controller: FSM states, error codes, default sync marker.
package uart_frame_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_e;

  // Running frame checksum: modulo-256 add.
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_frame_ctrl_frame_buf.sv
// Payload register file: one write port, one combinational read port, no reset (contents don't-care).
module uart_frame_ctrl_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          iCLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge iCLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser SYNC,ADDR,LEN,DATA[LEN],CHK -> burst of register writes once the checksum matches.
// CHK byte at edge t gives wr_en in cycles t+1..t+len; no backpressure, a byte during commit is dropped as overrun.
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 8680
) (
  input  logic       iCLK,
  input  logic       RST_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_CYC);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);

  state_e        state_q, state_d;
  logic [7:0]    base_q, base_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovr_q, ovr_d;
  logic          ovr_pend_q, ovr_pend_d;

  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  err_e          err_code_q, err_code_d;
  logic          busy_q, busy_d;

  logic          buf_we;
  logic [AW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;
  logic [TW-1:0] tmo_inc;
  logic          in_frame;
  logic          last_idx;
  logic          ovr_now;

  uart_frame_ctrl_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_frame_buf (
    .iCLK  (iCLK),
    .we    (buf_we),
    .waddr (idx_q[AW-1:0]),
    .wdata (rx_byte),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Entry 0 is read while still in CHK so the first write can issue on the commit edge.
  assign buf_raddr = (state_q == ST_COMMIT) ? idx_q[AW-1:0] : '0;
  assign tmo_inc   = tmo_q + TW'(1);
  assign in_frame  = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                     (state_q == ST_DATA) || (state_q == ST_CHK);
  assign last_idx  = (idx_q == (len_q - LEN_ONE));
  assign ovr_now   = ovr_q | rx_valid;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    tmo_d       = '0;
    ovr_d       = ovr_q;
    ovr_pend_d  = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    // Overrun is reported one cycle after the frame_ok of the commit it hit.
    if (ovr_pend_q) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_OVERRUN;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (rx_valid) begin
          base_d  = rx_byte;
          sum_d   = rx_byte;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (rx_valid) begin
          if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_IDLE;
          end else begin
            len_d   = rx_byte[LW-1:0];
            sum_d   = sum8(sum_q, rx_byte);
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          sum_d  = sum8(sum_q, rx_byte);
          if (last_idx) begin
            state_d = ST_CHK;
          end else begin
            idx_d = idx_q + LEN_ONE;
          end
        end
      end

      ST_CHK: begin
        if (rx_valid) begin
          if (rx_byte == sum_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = buf_rdata;
            idx_d     = LEN_ONE;
            ovr_d     = 1'b0;
            if (len_q == LEN_ONE) begin
              frame_ok_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_COMMIT;
            end
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_COMMIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = base_q + 8'(idx_q);
        wr_data_d = buf_rdata;
        idx_d     = idx_q + LEN_ONE;
        ovr_d     = ovr_now;
        if (last_idx) begin
          frame_ok_d = 1'b1;
          ovr_pend_d = ovr_now;
          ovr_d      = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A byte landing on the limit cycle wins over the timeout.
    if (in_frame) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_inc == TMO_LIM) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_inc;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      ovr_q       <= 1'b0;
      ovr_pend_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_LEN;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      ovr_q       <= ovr_d;
      ovr_pend_q  <= ovr_pend_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed-vector bench for uart_frame_ctrl; outputs are logged on the falling edge.
module tb_uart_frame_ctrl;

  logic       iCLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_frame_ctrl dut (
    .iCLK      (iCLK),
    .RST_n     (RST_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #10 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Falling-edge log: an output registered at rising edge e is logged as cycle e+1.
  int          ncyc = 0;
  logic [15:0] wr_log[$];
  int          wr_cyc[$];
  int          ok_n = 0;
  int          ok_cyc = -1;
  int          err_n = 0;
  int          err_cyc = -1;
  logic [1:0]  err_last = 2'd0;
  logic        busy_at_err = 1'b0;

  always @(negedge iCLK) begin
    ncyc++;
    if (wr_en) begin
      wr_log.push_back({wr_addr, wr_data});
      wr_cyc.push_back(ncyc);
    end
    if (frame_ok) begin
      ok_n++;
      ok_cyc = ncyc;
    end
    if (frame_err) begin
      err_n++;
      err_cyc = ncyc;
      err_last = err_code;
      busy_at_err = busy;
    end
  end

  function automatic logic [31:0] get_wr(input int i);
    return (wr_log.size() > i) ? 32'(wr_log[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] get_wc(input int i);
    return (wr_cyc.size() > i) ? 32'(wr_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    ok_n = 0;
    ok_cyc = -1;
    err_n = 0;
    err_cyc = -1;
  endtask

  // Strobe one byte into rising edge t; returns just after that edge.
  task automatic send(input logic [7:0] b, output int t);
    rx_byte = b;
    rx_valid = 1'b1;
    @(posedge iCLK);
    t = ncyc;
    #1;
    rx_valid = 1'b0;
  endtask

  logic [7:0] txq[$];

  task automatic send_q(output int t);
    t = 0;
    while (txq.size() > 0) begin
      send(txq.pop_front(), t);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  int t;
  int t2;

  initial begin
    // Reset state
    #25;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_frame_ok", 32'(frame_ok), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge iCLK);
    RST_n = 1'b1;
    idle(2);

    // 1: good frame, preceded by idle-state junk that must be ignored
    clear_logs();
    txq = '{8'h00, 8'h55, 8'hAA, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
    send_q(t);
    idle(5);
    chk("t1_wr_n", 32'(wr_log.size()), 2);
    chk("t1_wr0", get_wr(0), 32'h1011);
    chk("t1_wr1", get_wr(1), 32'h1122);
    chk("t1_wr0_cyc", get_wc(0), 32'(t + 1));
    chk("t1_wr1_cyc", get_wc(1), 32'(t + 2));
    chk("t1_ok_n", 32'(ok_n), 1);
    chk("t1_ok_cyc", 32'(ok_cyc), 32'(t + 2));
    chk("t1_err_n", 32'(err_n), 0);
    chk("t1_busy", 32'(busy), 0);

    // 2: checksum error
    clear_logs();
    txq = '{8'hAA, 8'h10, 8'h02, 8'h11, 8'h22};
    send_q(t);
    chk("t2_busy_pre", 32'(busy), 1);
    send(8'h46, t);
    idle(5);
    chk("t2_wr_n", 32'(wr_log.size()), 0);
    chk("t2_err_n", 32'(err_n), 1);
    chk("t2_code", 32'(err_last), 1);
    chk("t2_err_cyc", 32'(err_cyc), 32'(t + 1));
    chk("t2_busy_at_err", 32'(busy_at_err), 0);

    // 3: zero length, then length 17
    clear_logs();
    txq = '{8'hAA, 8'h10, 8'h00};
    send_q(t);
    idle(3);
    chk("t3a_err_n", 32'(err_n), 1);
    chk("t3a_code", 32'(err_last), 0);
    chk("t3a_err_cyc", 32'(err_cyc), 32'(t + 1));
    clear_logs();
    txq = '{8'hAA, 8'h10, 8'h11};
    send_q(t);
    idle(3);
    chk("t3b_err_n", 32'(err_n), 1);
    chk("t3b_code", 32'(err_last), 0);
    chk("t3b_busy", 32'(busy), 0);

    // 3c: maximum length 16, data 0..15, checksum 0x10+0x10+120 = 0x98
    clear_logs();
    txq = '{8'hAA, 8'h10, 8'h10};
    for (int i = 0; i < 16; i++) txq.push_back(8'(i));
    txq.push_back(8'h98);
    send_q(t);
    idle(20);
    chk("t3c_wr_n", 32'(wr_log.size()), 16);
    chk("t3c_wr0", get_wr(0), 32'h1000);
    chk("t3c_wr15", get_wr(15), 32'h1F0F);
    chk("t3c_ok_cyc", 32'(ok_cyc), 32'(t + 16));
    chk("t3c_err_n", 32'(err_n), 0);

    // 3d: sync value as ordinary address/data, len 1: sum AA+01+AA = 0x55
    clear_logs();
    txq = '{8'hAA, 8'hAA, 8'h01, 8'hAA, 8'h55};
    send_q(t);
    idle(4);
    chk("t3d_wr_n", 32'(wr_log.size()), 1);
    chk("t3d_wr0", get_wr(0), 32'hAAAA);
    chk("t3d_ok_cyc", 32'(ok_cyc), 32'(t + 1));

    // 4a: silence after a data byte times out
    clear_logs();
    txq = '{8'hAA, 8'h10, 8'h02, 8'h11};
    send_q(t);
    idle(8700);
    chk("t4a_err_n", 32'(err_n), 1);
    chk("t4a_code", 32'(err_last), 2);
    chk("t4a_err_cyc", 32'(err_cyc), 32'(t + 8681));
    chk("t4a_busy", 32'(busy), 0);

    // 4b: next byte exactly 8680 cycles later is accepted
    clear_logs();
    txq = '{8'hAA, 8'h10, 8'h02, 8'h11};
    send_q(t);
    repeat (8679) @(posedge iCLK);
    #1;
    send(8'h22, t2);
    idle(2);
    chk("t4b_err_n", 32'(err_n), 0);
    send(8'h45, t);
    idle(4);
    chk("t4b_ok_n", 32'(ok_n), 1);
    chk("t4b_wr1", get_wr(1), 32'h1122);

    // 5a: address wrap, sum FF+02+01+02 = 0x04
    clear_logs();
    txq = '{8'hAA, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h04};
    send_q(t);
    idle(4);
    chk("t5a_wr0", get_wr(0), 32'hFF01);
    chk("t5a_wr1", get_wr(1), 32'h0002);
    chk("t5a_ok_n", 32'(ok_n), 1);

    // 5b: strobe during commit
    clear_logs();
    txq = '{8'hAA, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h04};
    send_q(t);
    send(8'h33, t2);
    idle(5);
    chk("t5b_wr_n", 32'(wr_log.size()), 2);
    chk("t5b_wr1", get_wr(1), 32'h0002);
    chk("t5b_ok_cyc", 32'(ok_cyc), 32'(t + 2));
    chk("t5b_err_n", 32'(err_n), 1);
    chk("t5b_code", 32'(err_last), 3);
    chk("t5b_err_cyc", 32'(err_cyc), 32'(t + 3));
    chk("t5b_busy", 32'(busy), 0);

    // 6: reset mid-DATA, then a fresh frame: sum 20+02+33+44 = 0x99
    clear_logs();
    txq = '{8'hAA, 8'h10, 8'h02, 8'h11};
    send_q(t);
    #5;
    RST_n = 1'b0;
    #1;
    chk("t6_busy_in_rst", 32'(busy), 0);
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    RST_n = 1'b1;
    idle(3);
    chk("t6_wr_n_after_rst", 32'(wr_log.size()), 0);
    chk("t6_ok_n_after_rst", 32'(ok_n), 0);
    txq = '{8'hAA, 8'h20, 8'h02, 8'h33, 8'h44, 8'h99};
    send_q(t);
    idle(4);
    chk("t6_wr_n", 32'(wr_log.size()), 2);
    chk("t6_wr0", get_wr(0), 32'h2033);
    chk("t6_wr1", get_wr(1), 32'h2144);
    chk("t6_ok_n", 32'(ok_n), 1);
    chk("t6_err_n", 32'(err_n), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
